// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is visible on seq_state.
  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } seq_state_e;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOST_W  = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the raw input through the flop chain; cleared on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock acquisition, stability qualification and recovery.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
  parameter int unsigned LOCK_STABLE_CYC  = 5000,
  parameter int unsigned MAX_RETRIES      = 7,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic                sys_ready,
  output logic                fail,
  output logic [2:0]          seq_state,
  output logic [RETRY_W-1:0]  retry_cnt,
  output logic [LOST_W-1:0]   lock_lost_cnt
);

  localparam int unsigned PulseW = cnt_width(RST_PULSE_CYC);
  localparam int unsigned TmoW   = cnt_width(LOCK_TIMEOUT_CYC);
  localparam int unsigned StabW  = cnt_width(LOCK_STABLE_CYC);

  localparam logic [PulseW-1:0]  PulseLast = PulseW'(RST_PULSE_CYC - 1);
  localparam logic [TmoW-1:0]    TmoLast   = TmoW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [StabW-1:0]   StabLast  = StabW'(LOCK_STABLE_CYC - 1);
  // retry_cnt + 1 == MAX_RETRIES, compared without widening.
  localparam logic [RETRY_W-1:0] RetryLast = RETRY_W'(MAX_RETRIES - 1);

  seq_state_e         state_q, state_d;
  logic [PulseW-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [StabW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_d;

  logic locked_s;
  logic tmo_hit;
  logic stab_hit;

  sync_bit #(
    .Stages (SYNC_STAGES)
  ) u_sync_locked (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  assign tmo_hit  = (tmo_cnt_q == TmoLast);
  assign stab_hit = (stab_cnt_q == StabLast);

  // Next-state and counter updates; force_relock overrides every other event.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    retry_cnt_d = retry_cnt_q;
    lost_cnt_d  = lost_cnt_q;

    if (force_relock && (state_q != StReset)) begin
      state_d     = StReset;
      pulse_cnt_d = '0;
      retry_cnt_d = '0;
    end else begin
      unique case (state_q)
        StReset: begin
          if (pulse_cnt_q == PulseLast) begin
            state_d   = StWaitLock;
            tmo_cnt_d = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end

        StWaitLock: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_hit) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            if (retry_cnt_q == RetryLast) begin
              state_d = StFail;
            end else begin
              state_d     = StReset;
              pulse_cnt_d = '0;
            end
          end else if (locked_s) begin
            state_d    = StStable;
            stab_cnt_d = '0;
          end
        end

        StStable: begin
          tmo_cnt_d  = tmo_cnt_q + 1'b1;
          stab_cnt_d = stab_cnt_q + 1'b1;
          // Completing the stable window beats a coincident timeout.
          if (locked_s && stab_hit) begin
            state_d     = StRun;
            retry_cnt_d = '0;
          end else if (tmo_hit) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            if (retry_cnt_q == RetryLast) begin
              state_d = StFail;
            end else begin
              state_d     = StReset;
              pulse_cnt_d = '0;
            end
          end else if (!locked_s) begin
            // Lock glitch: requalify, but the attempt timer keeps running.
            state_d = StWaitLock;
          end
        end

        StRun: begin
          if (!locked_s) begin
            state_d     = StReset;
            pulse_cnt_d = '0;
            if (lost_cnt_q != '1) begin
              lost_cnt_d = lost_cnt_q + 1'b1;
            end
          end
        end

        StFail: begin
          state_d = StFail;
        end

        default: begin
          state_d     = StReset;
          pulse_cnt_d = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReset;
      pulse_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      retry_cnt_q <= '0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    pll_rst       = (state_q == StReset) || (state_q == StFail);
    sys_ready     = (state_q == StRun);
    fail          = (state_q == StFail);
    seq_state     = state_q;
    retry_cnt     = retry_cnt_q;
    lock_lost_cnt = lost_cnt_q;
  end

endmodule
